// File: rtl/vscale_md_arbiter.sv
// vscale_md_arbiter
//   Round-robin front end for the shared iterative mul/div unit. Two
//   requesters compete for the unit. The winner's operands are captured and
//   issued, and the single-cycle result is buffered until the owner takes it.
//   Only one operation is in flight at a time.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   reqN_valid/ready              request handshake (N = 0 pipeline, 1 secondary)
//   reqN_in_*_signed, op, out_sel,
//   reqN_in_1/2                   request fields
//   respN_valid/ready/result      response handshake and held result
//   md_req_*                      captured request driven into the unit
//   md_resp_valid/result          one-cycle result pulse from the unit
module vscale_md_arbiter #(
  parameter int XPR_LEN          = 32,
  parameter int MD_OP_WIDTH      = 2,
  parameter int MD_OUT_SEL_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic                        req0_in_1_signed,
  input  logic                        req0_in_2_signed,
  input  logic [MD_OP_WIDTH-1:0]      req0_op,
  input  logic [MD_OUT_SEL_WIDTH-1:0] req0_out_sel,
  input  logic [XPR_LEN-1:0]          req0_in_1,
  input  logic [XPR_LEN-1:0]          req0_in_2,
  output logic                        resp0_valid,
  input  logic                        resp0_ready,
  output logic [XPR_LEN-1:0]          resp0_result,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic                        req1_in_1_signed,
  input  logic                        req1_in_2_signed,
  input  logic [MD_OP_WIDTH-1:0]      req1_op,
  input  logic [MD_OUT_SEL_WIDTH-1:0] req1_out_sel,
  input  logic [XPR_LEN-1:0]          req1_in_1,
  input  logic [XPR_LEN-1:0]          req1_in_2,
  output logic                        resp1_valid,
  input  logic                        resp1_ready,
  output logic [XPR_LEN-1:0]          resp1_result,
  output logic                        md_req_valid,
  input  logic                        md_req_ready,
  output logic                        md_req_in_1_signed,
  output logic                        md_req_in_2_signed,
  output logic [MD_OP_WIDTH-1:0]      md_req_op,
  output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
  output logic [XPR_LEN-1:0]          md_req_in_1,
  output logic [XPR_LEN-1:0]          md_req_in_2,
  input  logic                        md_resp_valid,
  input  logic [XPR_LEN-1:0]          md_resp_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                        in_1_signed;
    logic                        in_2_signed;
    logic [MD_OP_WIDTH-1:0]      op;
    logic [MD_OUT_SEL_WIDTH-1:0] out_sel;
    logic [XPR_LEN-1:0]          in_1;
    logic [XPR_LEN-1:0]          in_2;
  } md_req_t;

  state_t               state, state_nxt;
  logic                 last_grant, owner;
  md_req_t              cap, req0_f, req1_f;
  logic [XPR_LEN-1:0]   res_buf;
  logic                 grant0, grant1, resp_take;

  assign req0_f = {req0_in_1_signed, req0_in_2_signed, req0_op, req0_out_sel, req0_in_1, req0_in_2};
  assign req1_f = {req1_in_1_signed, req1_in_2_signed, req1_op, req1_out_sel, req1_in_1, req1_in_2};

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    resp_take = owner ? resp1_ready : resp0_ready;
    case (state)
      S_IDLE: begin
        // reset_n gates the combinational readies so every output is quiet
        // while reset is held, even though state already reads S_IDLE.
        grant0 = reset_n && req0_valid && (!req1_valid || last_grant);
        grant1 = reset_n && req1_valid && !grant0;
        if (grant0 || grant1) state_nxt = S_ISSUE;
      end
      S_ISSUE: if (md_req_ready)  state_nxt = S_WAIT;
      S_WAIT:  if (md_resp_valid) state_nxt = S_RESP;
      S_RESP:  if (resp_take)     state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cap        <= '0;
      res_buf    <= '0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        owner <= grant1;
        cap   <= grant1 ? req1_f : req0_f;
      end
      if (state == S_WAIT && md_resp_valid) res_buf <= md_resp_result;
      if (state == S_RESP && resp_take)     last_grant <= owner;
    end
  end

  assign req0_ready         = grant0;
  assign req1_ready         = grant1;
  assign md_req_valid       = (state == S_ISSUE);
  assign md_req_in_1_signed = cap.in_1_signed;
  assign md_req_in_2_signed = cap.in_2_signed;
  assign md_req_op          = cap.op;
  assign md_req_out_sel     = cap.out_sel;
  assign md_req_in_1        = cap.in_1;
  assign md_req_in_2        = cap.in_2;
  assign resp0_valid        = (state == S_RESP) && !owner;
  assign resp1_valid        = (state == S_RESP) &&  owner;
  assign resp0_result       = resp0_valid ? res_buf : '0;
  assign resp1_result       = resp1_valid ? res_buf : '0;

endmodule
